// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = 5'd31;

  // EX operand source select; values match the datapath mux encoding.
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  // Shadow copy of what an in-flight instruction will write.
  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memtoreg;
    logic             setflags;
  } stage_info_t;

endpackage

// File: rtl/hazard_ctrl_slot.sv
// One tracking slot: a resettable stage_info_t register that loads a bubble
// (all zeros) instead of its input when asked.
module hazard_slot
  import hazard_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        bubble_i,
  input  stage_info_t d_i,
  output stage_info_t q_o
);

  stage_info_t slot_q;
  stage_info_t slot_d;

  // A bubble is simply an invalid, non-writing entry.
  always_comb begin
    slot_d = d_i;
    if (bubble_i) slot_d = '0;
  end

  // Slot register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i) slot_q <= '0;
    else          slot_q <= slot_d;
  end

  assign q_o = slot_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline with branches resolved in ID.
// Tracks EX/MEM/WB destinations and drives stalls, flushes and forwarding.
module hazard_ctrl #(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 31,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rb,
  input  logic             id_uses_a,
  input  logic             id_uses_b,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memtoreg,
  input  logic             id_setflags,
  input  logic             id_is_cbz,
  input  logic             id_uses_flags,
  input  logic             id_brtaken,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             br_take,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             flag_fwd,
  output logic [CNT_W-1:0] stall_cnt
);
  import hazard_ctrl_pkg::*;

  localparam logic [REG_W-1:0] ZREG = REG_W'(ZERO_REG);

  stage_info_t      id_info, ex_s, mem_s, wb_s;
  logic             stall, load_use, cbz_haz, ex_bubble;
  logic [REG_W-1:0] ex_rn_q, ex_rn_d, ex_rb_q, ex_rb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             unused_fields;

  // A slot is a hazard/forwarding source for r only if it really writes r.
  function automatic logic match(input stage_info_t s, input logic [REG_W-1:0] r);
    return s.v & s.regwrite & (s.rd == r) & (r != ZREG);
  endfunction

  // MEM has the younger value, so it wins over WB; loads in MEM are excluded
  // because their data is not ready until WB.
  function automatic logic [1:0] fwd_for(input logic [REG_W-1:0] r);
    if (match(mem_s, r) && !mem_s.memtoreg) return FWD_EXMEM;
    if (match(wb_s, r))                     return FWD_MEMWB;
    return FWD_RF;
  endfunction

  assign id_info   = {id_valid, id_rd, id_regwrite, id_memtoreg, id_setflags};
  assign load_use  = id_valid & ex_s.memtoreg &
                     ((id_uses_a & match(ex_s, id_rn)) | (id_uses_b & match(ex_s, id_rb)));
  assign cbz_haz   = id_valid & id_is_cbz & (match(ex_s, id_rb) | match(mem_s, id_rb));
  assign stall     = load_use | cbz_haz;
  assign ex_bubble = stall | ~id_valid;

  // Tracking slots; the stages below ID never freeze, only EX gets bubbles.
  hazard_slot u_ex_slot  (.clk_i(clk), .reset_i(reset), .bubble_i(ex_bubble), .d_i(id_info), .q_o(ex_s));
  hazard_slot u_mem_slot (.clk_i(clk), .reset_i(reset), .bubble_i(1'b0),      .d_i(ex_s),    .q_o(mem_s));
  hazard_slot u_wb_slot  (.clk_i(clk), .reset_i(reset), .bubble_i(1'b0),      .d_i(mem_s),   .q_o(wb_s));

  // Source specifiers of the EX instruction; a bubble reads only XZR.
  always_comb begin
    ex_rn_d = id_rn;
    ex_rb_d = id_rb;
    if (ex_bubble) begin
      ex_rn_d = ZREG;
      ex_rb_d = ZREG;
    end
  end

  // Register the EX source specifiers alongside the EX slot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_rn_q <= ZREG;
      ex_rb_q <= ZREG;
    end else begin
      ex_rn_q <= ex_rn_d;
      ex_rb_q <= ex_rb_d;
    end
  end

  // Saturating stall counter next value.
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // Stall cycle counter register.
  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign stall_cnt = cnt_q;

  // Pipeline control; reset holds the front end and injects NOPs/bubbles.
  always_comb begin
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b1;
    idex_bubble = 1'b1;
    br_take     = 1'b0;
    fwd_a       = FWD_RF;
    fwd_b       = FWD_RF;
    flag_fwd    = 1'b0;
    if (reset) begin
      br_take     = id_valid & id_brtaken & ~stall;
      pc_we       = ~stall;
      ifid_we     = ~stall;
      idex_bubble = stall;
      ifid_flush  = br_take;
      fwd_a       = fwd_for(ex_rn_q);
      fwd_b       = fwd_for(ex_rb_q);
      flag_fwd    = id_uses_flags & ex_s.v & ex_s.setflags;
    end
  end

  // Fields carried for completeness but not needed for any decision.
  assign unused_fields = ^{mem_s.setflags, wb_s.memtoreg, wb_s.setflags};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: cycle-by-cycle vector table plus a hand-written
// reset-during-stall sequence, checked through an expected-value queue.
module tb_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic        id_valid, id_uses_a, id_uses_b, id_regwrite, id_memtoreg;
  logic        id_setflags, id_is_cbz, id_uses_flags, id_brtaken;
  logic [4:0]  id_rn, id_rb, id_rd;
  logic        pc_we, ifid_we, ifid_flush, idex_bubble, br_take, flag_fwd;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_cnt;

  hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rb(id_rb),
    .id_uses_a(id_uses_a), .id_uses_b(id_uses_b), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg), .id_setflags(id_setflags),
    .id_is_cbz(id_is_cbz), .id_uses_flags(id_uses_flags), .id_brtaken(id_brtaken),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .br_take(br_take), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .flag_fwd(flag_fwd), .stall_cnt(stall_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus records ----------------
  typedef struct packed {
    logic       rst;
    logic       valid;
    logic [4:0] rn, rb;
    logic       ua, ub;
    logic [4:0] rd;
    logic       rw, mtr, sf, cbz, uf, brt;
  } id_t;

  typedef struct {
    id_t         in;
    logic [41:0] exp;
    string       tag;
  } vec_t;

  vec_t        tab[$];
  logic [41:0] exp_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          errors = 0;

  function automatic id_t mk(logic v, logic [4:0] rn, logic [4:0] rb, logic ua, logic ub,
                             logic [4:0] rd, logic rw, logic mtr, logic sf, logic cz,
                             logic uf, logic brt);
    id_t r;
    r = '0;
    r.rst = 1'b1; r.valid = v; r.rn = rn; r.rb = rb; r.ua = ua; r.ub = ub;
    r.rd = rd; r.rw = rw; r.mtr = mtr; r.sf = sf; r.cbz = cz; r.uf = uf; r.brt = brt;
    return r;
  endfunction

  function automatic id_t nop();
    return mk(0, 31, 31, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic id_t alu(logic [4:0] rd, logic [4:0] rn, logic [4:0] rb, logic sf);
    return mk(1, rn, rb, 1, 1, rd, 1, 0, sf, 0, 0, 0);
  endfunction
  function automatic id_t ldur(logic [4:0] rd, logic [4:0] rn);
    return mk(1, rn, 31, 1, 0, rd, 1, 1, 0, 0, 0, 0);
  endfunction
  function automatic id_t cbz(logic [4:0] rt, logic taken);
    return mk(1, 31, rt, 0, 1, 5'd31, 0, 0, 0, 1, 0, taken);
  endfunction
  function automatic id_t bcond(logic taken);
    return mk(1, 31, 31, 0, 0, 5'd31, 0, 0, 0, 0, 1, taken);
  endfunction
  function automatic id_t in_reset(id_t s);
    id_t r;
    r = s;
    r.rst = 1'b0;
    return r;
  endfunction

  // Expected = {pc_we, ifid_we, ifid_flush, idex_bubble, br_take, fwd_a, fwd_b, flag_fwd, stall_cnt}
  function automatic logic [41:0] e_run(logic [1:0] fa, logic [1:0] fb, logic ff, int unsigned c);
    return {5'b11000, fa, fb, ff, 32'(c)};
  endfunction
  function automatic logic [41:0] e_stall(int unsigned c);
    return {5'b00010, 2'b00, 2'b00, 1'b0, 32'(c)};
  endfunction
  function automatic logic [41:0] e_br(logic ff, int unsigned c);
    return {5'b11101, 2'b00, 2'b00, ff, 32'(c)};
  endfunction
  function automatic logic [41:0] e_rst(int unsigned c);
    return {5'b00110, 2'b00, 2'b00, 1'b0, 32'(c)};
  endfunction

  function automatic void add(id_t in, logic [41:0] e, string tag);
    tab.push_back('{in, e, tag});
  endfunction

  function automatic void add_drain(int unsigned c, string tag);
    for (int i = 0; i < 3; i++) add(nop(), e_run(2'b00, 2'b00, 1'b0, c), tag);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input id_t s);
    reset         = s.rst;
    id_valid      = s.valid;
    id_rn         = s.rn;
    id_rb         = s.rb;
    id_uses_a     = s.ua;
    id_uses_b     = s.ub;
    id_rd         = s.rd;
    id_regwrite   = s.rw;
    id_memtoreg   = s.mtr;
    id_setflags   = s.sf;
    id_is_cbz     = s.cbz;
    id_uses_flags = s.uf;
    id_brtaken    = s.brt;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_out();
    logic [41:0] got, e;
    string       tag;
    got = {pc_we, ifid_we, ifid_flush, idex_bubble, br_take, fwd_a, fwd_b, flag_fwd, stall_cnt};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: got ctl=%b with no expected entry queued", got[41:32]);
    end else begin
      e   = exp_q.pop_front();
      tag = tag_q.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got pc/ifid/flush/bub/br=%b fa=%b fb=%b ff=%b cnt=%0d, want %b fa=%b fb=%b ff=%b cnt=%0d",
                 tag, got[41:37], got[36:35], got[34:33], got[32], got[31:0],
                 e[41:37], e[36:35], e[34:33], e[32], e[31:0]);
      end
    end
  endtask

  // Inputs change just after posedge; outputs are sampled on the negedge.
  task automatic step(input id_t s, input logic [41:0] e, input string tag);
    @(posedge clk);
    #1;
    drive(s);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    check_out();
  endtask

  // ---------------- test ----------------
  initial begin
    drive(in_reset(nop()));

    // Reset: forced outputs, counter cleared.
    add(in_reset(nop()), e_rst(0), "reset0");
    add(in_reset(nop()), e_rst(0), "reset1");

    // ADDS X1 ; LDUR X2,[X1]: EX/MEM forward on the load's EX cycle, no stall.
    add(alu(5'd1, 5'd2, 5'd3, 1'b1), e_run(2'b00, 2'b00, 1'b0, 0), "adds_x1");
    add(ldur(5'd2, 5'd1),             e_run(2'b00, 2'b00, 1'b0, 0), "ldur_after_adds");
    add(nop(),                        e_run(2'b01, 2'b00, 1'b0, 0), "fwd_a_exmem");
    add_drain(0, "drain1");

    // LDUR X3 ; ADD X4,X3,X5: one stall, then MEM/WB forward.
    add(ldur(5'd3, 5'd7),             e_run(2'b00, 2'b00, 1'b0, 0), "ldur_x3");
    add(alu(5'd4, 5'd3, 5'd5, 1'b0),  e_stall(0),                   "load_use_stall");
    add(alu(5'd4, 5'd3, 5'd5, 1'b0),  e_run(2'b00, 2'b00, 1'b0, 1), "load_use_release");
    add(nop(),                        e_run(2'b10, 2'b00, 1'b0, 1), "fwd_a_memwb");
    add_drain(1, "drain2");

    // ADD X6 ; CBZ X6 (taken): two stalls, then taken branch with flush.
    add(alu(5'd6, 5'd8, 5'd9, 1'b0),  e_run(2'b00, 2'b00, 1'b0, 1), "add_x6");
    add(cbz(5'd6, 1'b1),              e_stall(1),                   "cbz_stall_ex");
    add(cbz(5'd6, 1'b1),              e_stall(2),                   "cbz_stall_mem");
    add(cbz(5'd6, 1'b1),              e_br(1'b0, 3),                "cbz_taken");
    add_drain(3, "drain3");

    // SUBS ; B.LT: live flags forwarded, no stall.
    add(alu(5'd10, 5'd11, 5'd12, 1'b1), e_run(2'b00, 2'b00, 1'b0, 3), "subs");
    add(bcond(1'b1),                    e_br(1'b1, 3),                "bcond_flag_fwd");
    add_drain(3, "drain4");

    // SUBS ; NOP ; B.LT: flags already in registers.
    add(alu(5'd10, 5'd11, 5'd12, 1'b1), e_run(2'b00, 2'b00, 1'b0, 3), "subs2");
    add(nop(),                          e_run(2'b00, 2'b00, 1'b0, 3), "gap_nop");
    add(bcond(1'b0),                    e_run(2'b00, 2'b00, 1'b0, 3), "bcond_no_fwd");
    add_drain(3, "drain5");

    // Load into X31 ; ADD using X31: never a hazard or forwarding source.
    add(ldur(5'd31, 5'd13),             e_run(2'b00, 2'b00, 1'b0, 3), "ldur_x31");
    add(alu(5'd14, 5'd31, 5'd31, 1'b0), e_run(2'b00, 2'b00, 1'b0, 3), "x31_no_stall");
    add(nop(),                          e_run(2'b00, 2'b00, 1'b0, 3), "x31_no_fwd_load");
    add_drain(3, "drain6");

    // ALU write to X31 ; ADD using X31: still no forwarding.
    add(alu(5'd31, 5'd1, 5'd2, 1'b1),   e_run(2'b00, 2'b00, 1'b0, 3), "cmp_x31");
    add(alu(5'd22, 5'd31, 5'd31, 1'b0), e_run(2'b00, 2'b00, 1'b0, 3), "use_x31");
    add(nop(),                          e_run(2'b00, 2'b00, 1'b0, 3), "x31_no_fwd_alu");
    add_drain(3, "drain7");

    // Double producer of X15: MEM wins over WB on both operands.
    add(alu(5'd15, 5'd1, 5'd2, 1'b0),   e_run(2'b00, 2'b00, 1'b0, 3), "x15_first");
    add(alu(5'd15, 5'd3, 5'd4, 1'b0),   e_run(2'b00, 2'b00, 1'b0, 3), "x15_second");
    add(alu(5'd16, 5'd15, 5'd15, 1'b0), e_run(2'b00, 2'b00, 1'b0, 3), "x15_user");
    add(nop(),                          e_run(2'b01, 2'b01, 1'b0, 3), "mem_beats_wb");
    add_drain(3, "drain8");

    // Operand B forwarded from WB.
    add(alu(5'd17, 5'd1, 5'd2, 1'b0),   e_run(2'b00, 2'b00, 1'b0, 3), "x17");
    add(nop(),                          e_run(2'b00, 2'b00, 1'b0, 3), "x17_gap");
    add(alu(5'd18, 5'd2, 5'd17, 1'b0),  e_run(2'b00, 2'b00, 1'b0, 3), "x17_user");
    add(nop(),                          e_run(2'b00, 2'b10, 1'b0, 3), "fwd_b_memwb");
    add_drain(3, "drain9");

    // LDUR X19 ; NOP ; CBZ X19 (not taken): one stall while the load is in MEM.
    add(ldur(5'd19, 5'd13),             e_run(2'b00, 2'b00, 1'b0, 3), "ldur_x19");
    add(nop(),                          e_run(2'b00, 2'b00, 1'b0, 3), "x19_gap");
    add(cbz(5'd19, 1'b0),               e_stall(3),                   "cbz_stall_load_mem");
    add(cbz(5'd19, 1'b0),               e_run(2'b00, 2'b00, 1'b0, 4), "cbz_not_taken");
    add_drain(4, "drain10");

    foreach (tab[i]) step(tab[i].in, tab[i].exp, tab[i].tag);

    // Reset in the middle of a load-use stall, then release with ID unchanged.
    step(ldur(5'd20, 5'd13),                      e_run(2'b00, 2'b00, 1'b0, 4), "ldur_x20");
    step(alu(5'd21, 5'd20, 5'd1, 1'b0),           e_stall(4),                   "stall_before_reset");
    step(in_reset(alu(5'd21, 5'd20, 5'd1, 1'b0)), e_rst(5),                     "reset_mid_stall");
    step(alu(5'd21, 5'd20, 5'd1, 1'b0),           e_run(2'b00, 2'b00, 1'b0, 0), "clean_after_reset");
    step(nop(),                                   e_run(2'b00, 2'b00, 1'b0, 0), "idle_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Sequences the 5-stage pipelined CPU (IF, ID, EX, MEM, WB).
- Keeps its own shadow copy of the destination and control info of in-flight instructions in EX, MEM and WB.
- From that copy it drives the pipeline-register enables, bubbles and flushes, the EX operand forwarding selects, and the flag forwarding select.
- Branches resolve in ID; the register file has internal write-through, so a WB write is visible to an ID read in the same cycle.

Parameters:
- REG_W, 5, register-specifier width
- ZERO_REG, 31, register that is never a hazard or forwarding source (XZR)
- CNT_W, 32, width of the stall performance counter

Ports:
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-low (0 = reset, sampled on posedge clk)
- id_valid  in  1  ID holds a real instruction
- id_rn  in  REG_W  ID source A (instr[9:5])
- id_rb  in  REG_W  ID source B after the Reg2Loc mux
- id_uses_a  in  1  ID instruction reads Rn
- id_uses_b  in  1  ID instruction reads the B source (includes STUR data and CBZ Rt)
- id_rd  in  REG_W  ID destination
- id_regwrite  in  1  ID instruction writes Rd
- id_memtoreg  in  1  ID instruction is a load
- id_setflags  in  1  ID instruction writes flags
- id_is_cbz  in  1  ID instruction is CBZ (register compared in ID)
- id_uses_flags  in  1  ID instruction is B.cond
- id_brtaken  in  1  raw branch-taken decision from control
- pc_we  out  1  PC load enable
- ifid_we  out  1  IF/ID register enable
- ifid_flush  out  1  IF/ID loads a NOP on the next edge
- idex_bubble  out  1  ID/EX loads all-zero controls on the next edge
- br_take  out  1  gated branch select for the PC mux
- fwd_a  out  2  EX operand A source: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB write data
- fwd_b  out  2  EX operand B source, same encoding as fwd_a
- flag_fwd  out  1  B.cond uses live ALU flags instead of the flag registers
- stall_cnt  out  CNT_W  count of stall cycles

Behaviour:
- State: three tracking slots (EX, MEM, WB), each holding {v, rd, regwrite, memtoreg, setflags}.
- Slot advance, every cycle while reset=1:
  - EX slot takes the ID info, or zeros when a stall occurs or id_valid=0.
  - MEM takes EX; WB takes MEM.
  - The pipeline never freezes below ID.
- Match condition: match(s, r) = s.v & s.regwrite & (s.rd == r) & (r != ZERO_REG).
- Load-use: load_use = id_valid & EX.memtoreg & ((id_uses_a & match(EX, id_rn)) | (id_uses_b & match(EX, id_rb))).
- CBZ hazard: cbz_haz = id_valid & id_is_cbz & (match(EX, id_rb) | match(MEM, id_rb)).
  - CBZ therefore stalls until its producer reaches WB: 2 cycles behind an ALU op or load in EX, 1 cycle behind one in MEM.
- stall = load_use | cbz_haz. When stall=1: pc_we=0, ifid_we=0, idex_bubble=1, br_take=0.
- Branch: br_take = id_valid & id_brtaken & ~stall. When br_take=1, ifid_flush=1 (one-cycle penalty), pc_we=1.
- Operand forwarding (combinational from slots and the registered ID/EX specifiers):
  - The block keeps ex_rn and ex_rb internally, captured alongside the EX slot.
  - fwd_x = 01 if match(MEM, ex_rx) & ~MEM.memtoreg; else 10 if match(WB, ex_rx); else 00.
  - MEM wins over WB on a double match.
  - A load in MEM never reaches this point, because load-use already stalled it.
- Flag forwarding: flag_fwd = id_uses_flags & EX.v & EX.setflags. No stall is needed, because flags are computed in EX.
- Simultaneous stall and taken branch: the stall wins. The branch is re-evaluated once the hazard clears.
- stall_cnt: increments every cycle with stall=1 and saturates at all-ones.
- Reset (reset=0 at posedge):
  - All slots invalid; stall_cnt=0.
  - While reset=0, outputs are forced to pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, br_take=0, fwd_a=fwd_b=00, flag_fwd=0.
  - Reset asserted mid-stall discards the in-flight hazard; the first cycle after release has no hazard.
- Latency: every output is combinational from registered slots plus current ID inputs. No output is registered except stall_cnt.

Decomposition:
- Shared package: fwd_sel_t enum (FWD_RF, FWD_EXMEM, FWD_MEMWB), the stage_info_t struct {v, rd, regwrite, memtoreg, setflags}, and the ZERO_REG constant.
- One sub-module, hazard_slot: a resettable stage_info_t register with a bubble input, instantiated three times.

Test Plan:
- ADDS X1 then LDUR X2,[X1] back-to-back -> fwd_a=01 on the load's EX cycle; no stall; stall_cnt stays 0.
- LDUR X3 then ADD X4,X3,X5 -> exactly one cycle with pc_we=0, ifid_we=0, idex_bubble=1; then fwd_a=10; stall_cnt=1.
- ADD X6 followed directly by CBZ X6 -> 2 stall cycles, then br_take=1 and ifid_flush=1 for one cycle; stall_cnt=2.
- SUBS then B.LT in ID -> flag_fwd=1 and no stall. Repeated with a NOP between them -> flag_fwd=0.
- Write X31 by load, then ADD using X31 -> no stall, fwd_a=fwd_b=00.
- Assert reset=0 in the middle of a load-use stall -> next cycle shows the forced reset outputs. After release with a clean ID, stall=0 and stall_cnt=0.
